// File: rtl/lcd_write_scheduler.sv
// Buffers single-cycle core LCD writes in a FIFO and issues them one at a time to a slow LCD
// controller, honouring its busy flag and a minimum inter-write gap. Option: LCD_SCHED_CR_EXPAND_EN.
module lcd_write_scheduler #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_wr_req,
    input  logic [DATA_W-1:0]        i_wr_data,
    output logic                     o_stall,
    input  logic                     i_clr_ovf,
    output logic                     o_overflow,
    input  logic                     i_lcd_busy,
    output logic                     o_lcd_we,
    output logic [DATA_W-1:0]        o_lcd_dout,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StIssue, StGap, StWait} state_t;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_rptr;
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W:0]    r_count;
    logic              r_overflow;
    state_t            r_state;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic              r_lcd_we;
    logic [DATA_W-1:0] r_lcd_dout;

    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_enter_issue;
    logic [DATA_W-1:0] w_head;
    logic [DATA_W-1:0] w_issue_data;

    assign w_full  = (r_count == FULL_LVL);
    assign w_empty = (r_count == '0);
    assign w_head  = r_mem[r_rptr];

`ifdef LCD_SCHED_CR_EXPAND_EN
    logic r_cr_pending;
    logic w_cr_next;

    // A newline entry is emitted as CR (entry kept) and then LF (entry popped).
    always_comb begin
        w_issue_data = w_head;
        w_cr_next    = 1'b0;
        if (r_cr_pending) begin
            w_issue_data = DATA_W'(8'h0A);
        end else if (w_head == DATA_W'(8'h0A)) begin
            w_issue_data = DATA_W'(8'h0D);
            w_cr_next    = 1'b1;
        end
    end

    assign w_pop = (r_state == StIssue) && !r_cr_pending;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cr_pending <= 1'b0;
        end else if (w_enter_issue) begin
            r_cr_pending <= w_cr_next;
        end
    end
`else
    assign w_issue_data = w_head;
    assign w_pop        = (r_state == StIssue);
`endif

    assign w_push        = i_wr_req && (!w_full || w_pop);
    assign w_enter_issue = !w_empty && !i_lcd_busy &&
                           ((r_state == StIdle) || (r_state == StWait));

    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rptr     <= '0;
            r_wptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Set takes priority over a coincident clear.
            if (i_wr_req && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_gap_cnt  <= '0;
            r_lcd_we   <= 1'b0;
            r_lcd_dout <= '0;
        end else begin
            r_lcd_we <= 1'b0;
            if (w_enter_issue) begin
                r_state    <= StIssue;
                r_lcd_we   <= 1'b1;
                r_lcd_dout <= w_issue_data;
            end else begin
                unique case (r_state)
                    StIssue: begin
                        if (GAP_CYCLES > 0) begin
                            r_state   <= StGap;
                            r_gap_cnt <= GAP_W'(GAP_LOAD);
                        end else begin
                            r_state <= StWait;
                        end
                    end
                    StGap: begin
                        if (r_gap_cnt == '0) r_state <= StWait;
                        else                 r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                    // Not entering ISSUE from WAIT with busy low means the FIFO is empty.
                    StWait: if (!i_lcd_busy) r_state <= StIdle;
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    assign o_stall    = w_full;
    assign o_overflow = r_overflow;
    assign o_lcd_we   = r_lcd_we;
    assign o_lcd_dout = r_lcd_dout;
    assign o_level    = r_count;

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Directed bench for lcd_write_scheduler (DEPTH=8, GAP_CYCLES=4): a per-cycle vector table plus
// hand-written sequences for draining, busy hold, reset and (if enabled) CR expansion.
module tb_lcd_write_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_req = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       clr_ovf = 1'b0;
    logic       lcd_busy = 1'b0;
    logic       stall;
    logic       overflow;
    logic       lcd_we;
    logic [7:0] lcd_dout;
    logic [3:0] level;

    lcd_write_scheduler #(
        .DEPTH      (8),
        .DATA_W     (8),
        .GAP_CYCLES (4)
    ) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_wr_req   (wr_req),
        .i_wr_data  (wr_data),
        .o_stall    (stall),
        .i_clr_ovf  (clr_ovf),
        .o_overflow (overflow),
        .i_lcd_busy (lcd_busy),
        .o_lcd_we   (lcd_we),
        .o_lcd_dout (lcd_dout),
        .o_level    (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [7:0] data;
        logic       busy;
        logic       clr;
        logic       we;
        logic [7:0] dout;
        logic [3:0] lvl;
        logic       stall;
        logic       ovf;
    } vec_t;

    vec_t       vecs[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         p_n     = 0;
    logic [7:0] p_data [16];
    int         p_cyc  [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one edge, sample 1 ns later and log any write pulse.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (lcd_we && p_n < 16) begin
            p_data[p_n] = lcd_dout;
            p_cyc[p_n]  = cyc;
            p_n++;
        end
    endtask

    task automatic run_until(input int n, input int budget, input string name);
        for (int i = 0; i < budget && p_n < n; i++) step();
        chk(name, p_n, n);
    endtask

    task automatic add(input logic wr, input logic [7:0] data, input logic busy, input logic clr,
                       input logic we, input logic [7:0] dout, input logic [3:0] lvl,
                       input logic st, input logic ovf);
        vec_t v;
        v.wr = wr; v.data = data; v.busy = busy; v.clr = clr;
        v.we = we; v.dout = dout; v.lvl = lvl; v.stall = st; v.ovf = ovf;
        vecs.push_back(v);
    endtask

    initial begin
        // Single write, then fill to full under busy, overflow, set-beats-clear, push+pop when full
        add(1, 8'h41, 0, 0, 0, 8'h00, 1, 0, 0);
        add(0, 8'h00, 0, 0, 1, 8'h41, 1, 0, 0);
        for (int i = 0; i < 6; i++) add(0, 8'h00, 0, 0, 0, 8'h41, 0, 0, 0);
        for (int k = 1; k <= 8; k++)
            add(1, 8'h50 + 8'(k), 1, 0, 0, 8'h41, 4'(k), (k == 8), 0);
        add(1, 8'h59, 1, 0, 0, 8'h41, 8, 1, 1);
        add(1, 8'h5A, 1, 1, 0, 8'h41, 8, 1, 1);
        add(0, 8'h00, 0, 0, 1, 8'h51, 8, 1, 1);
        add(1, 8'h5B, 0, 0, 0, 8'h51, 8, 1, 1);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_we", lcd_we, 0);
        chk("reset_dout", lcd_dout, 0);
        chk("reset_level", level, 0);
        chk("reset_stall", stall, 0);
        chk("reset_ovf", overflow, 0);
        @(negedge clk);
        rst = 1'b0;

        p_n = 0;
        foreach (vecs[i]) begin
            wr_req = vecs[i].wr; wr_data = vecs[i].data;
            lcd_busy = vecs[i].busy; clr_ovf = vecs[i].clr;
            step();
            chk($sformatf("vec%0d_we", i), lcd_we, vecs[i].we);
            chk($sformatf("vec%0d_dout", i), lcd_dout, vecs[i].dout);
            chk($sformatf("vec%0d_level", i), level, vecs[i].lvl);
            chk($sformatf("vec%0d_stall", i), stall, vecs[i].stall);
            chk($sformatf("vec%0d_ovf", i), overflow, vecs[i].ovf);
        end
        wr_req = 0; clr_ovf = 0; lcd_busy = 0;

        // Drain: 52..58 then 5B, each 6 cycles after the previous pulse
        run_until(10, 80, "drain_count");
        for (int i = 2; i < 10; i++) begin
            chk($sformatf("drain%0d_data", i), p_data[i], (i == 9) ? 8'h5B : 8'h50 + 8'(i));
            chk($sformatf("drain%0d_gap", i), p_cyc[i] - p_cyc[i-1], 6);
        end
        repeat (7) step();
        chk("drain_level", level, 0);
        chk("drain_stall", stall, 0);
        chk("drain_ovf_held", overflow, 1);
        clr_ovf = 1;
        step();
        clr_ovf = 0;
        chk("clr_ovf", overflow, 0);

        // Back-to-back A, B, C
        p_n = 0;
        wr_req = 1; wr_data = 8'h41; step();
        begin
            int c0;
            c0 = cyc;
            wr_data = 8'h42; step();
            wr_data = 8'h43; step();
            wr_req = 0;
            run_until(3, 40, "b2b_count");
            chk("b2b_latency", p_cyc[0] - c0, 1);
        end
        for (int i = 0; i < 3; i++) chk($sformatf("b2b%0d_data", i), p_data[i], 8'h41 + 8'(i));
        chk("b2b_gap1", p_cyc[1] - p_cyc[0], 6);
        chk("b2b_gap2", p_cyc[2] - p_cyc[1], 6);
        repeat (7) step();

        // Busy through GAP plus 10 WAIT cycles
        p_n = 0;
        wr_req = 1; wr_data = 8'h61; step();
        wr_data = 8'h62; step();
        chk("busy_first_we", lcd_we, 1);
        chk("busy_first_dout", lcd_dout, 8'h61);
        wr_req = 0; lcd_busy = 1;
        repeat (15) step();
        chk("busy_hold_pulses", p_n, 1);
        chk("busy_hold_level", level, 1);
        lcd_busy = 0;
        step();
        chk("busy_release_we", lcd_we, 1);
        chk("busy_release_dout", lcd_dout, 8'h62);
        repeat (7) step();
        chk("busy_end_level", level, 0);

        // Reset during ISSUE with three entries queued
        lcd_busy = 1; wr_req = 1;
        for (int i = 0; i < 3; i++) begin
            wr_data = 8'h71 + 8'(i);
            step();
        end
        wr_req = 0; lcd_busy = 0;
        step();
        chk("pre_reset_we", lcd_we, 1);
        chk("pre_reset_dout", lcd_dout, 8'h71);
        chk("pre_reset_level", level, 3);
        #3 rst = 1'b1;
        #1;
        chk("async_reset_we", lcd_we, 0);
        chk("async_reset_level", level, 0);
        chk("async_reset_dout", lcd_dout, 0);
        @(negedge clk);
        rst = 1'b0;
        p_n = 0;
        repeat (12) step();
        chk("post_reset_pulses", p_n, 0);
        chk("post_reset_level", level, 0);

`ifdef LCD_SCHED_CR_EXPAND_EN
        p_n = 0;
        wr_req = 1; wr_data = 8'h0A; step();
        wr_req = 0;
        run_until(1, 10, "cr_first_count");
        chk("cr_first_data", p_data[0], 8'h0D);
        run_until(2, 20, "cr_second_count");
        chk("cr_second_data", p_data[1], 8'h0A);
        chk("cr_spacing", p_cyc[1] - p_cyc[0], 6);
        chk("cr_level_before_pop", level, 1);
        step();
        chk("cr_level_after_pop", level, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_write_scheduler.md
Name: lcd_write_scheduler

Overview:
- Decouples the core's single-cycle LCD write strobe from the slower LCD character controller.
- Sits between the processor's lcd_write/lcd_data outputs and the LCD controller.
- Buffers characters in a small FIFO and issues them one at a time, honouring the controller's busy flag and a minimum inter-write gap.
- Raises stall to the core when the FIFO is full, so no character is lost.

Parameters:
DEPTH, 8, FIFO entries; power of 2, at least 2.
DATA_W, 8, character width in bits.
GAP_CYCLES, 4, idle cycles forced after each lcd_we pulse; 0 is legal.

Ports:
clock  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset; clears all state.
wr_req  input  1  core write strobe (the core's lcd_write); sampled each rising edge.
wr_data  input  DATA_W  character accompanying wr_req.
stall  output  1  FIFO full; the core must hold the write.
clr_ovf  input  1  synchronous clear of the overflow flag.
overflow  output  1  sticky flag: a write was dropped.
lcd_busy  input  1  LCD controller busy; no issue while high.
lcd_we  output  1  one-cycle write pulse to the LCD controller.
lcd_dout  output  DATA_W  character to the LCD controller; valid while lcd_we is high.
level  output  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values (applied asynchronously): lcd_we=0, lcd_dout=0, stall=0, overflow=0, level=0, FSM=IDLE, gap counter=0. FIFO contents are discarded.
- Reset asserted mid-operation: lcd_we drops immediately; any in-flight character is lost.
- FIFO: circular buffer with read/write pointers plus a count; pointers wrap modulo DEPTH.
  - push = wr_req & (!full | pop).
  - pop occurs on the clock edge that leaves ISSUE, unless the CR-expansion first half is in progress (see Optional Feature).
- Full boundary:
  - stall = (level==DEPTH), driven from the registered count.
  - Simultaneous push and pop while full: both are accepted and level is unchanged.
- Empty boundary: pop never occurs while empty; the FSM does not enter ISSUE when level==0.
- Overflow:
  - Set on any edge where wr_req & full & !pop.
  - Cleared by clr_ovf; if set and clear coincide, set wins.
- FSM states:
  - IDLE: go to ISSUE when level!=0 & !lcd_busy; otherwise stay.
  - ISSUE: lcd_we=1 for exactly one cycle; lcd_dout = head entry, registered on entry. Go to GAP if GAP_CYCLES>0, else go to WAIT.
  - GAP: counter loads GAP_CYCLES-1 on entry and decrements each cycle; at 0 go to WAIT. GAP therefore lasts exactly GAP_CYCLES cycles.
  - WAIT: if lcd_busy, stay. If !lcd_busy & level!=0, go to ISSUE. If !lcd_busy & level==0, go to IDLE.
- lcd_dout holds its last issued value outside ISSUE.
- Latency: with wr_req sampled at edge E0 into an empty FIFO, FSM in IDLE and lcd_busy=0, lcd_we is high from edge E1 to edge E2.
- Throughput: one character per GAP_CYCLES+2 cycles while lcd_busy stays low.
- lcd_busy rising during GAP has no effect until WAIT.

Optional Feature:
- Macro: LCD_SCHED_CR_EXPAND_EN.
- Defined:
  - When the head entry equals 8'h0A, ISSUE first emits 8'h0D without popping and sets an internal cr_pending flag.
  - The normal GAP and WAIT sequence follows.
  - The next ISSUE then emits 8'h0A, pops the entry and clears cr_pending.
  - Reset clears cr_pending.
  - level counts FIFO entries only, not emitted characters.
- Undefined: all data passes through verbatim, one pulse per entry.

Test Plan:
- Single write: reset, then wr_req=1 with wr_data=8'h41 for one cycle, lcd_busy=0 -> lcd_we pulses at E1 with lcd_dout=8'h41; level goes 1 then 0; lcd_we stays low afterwards.
- Back-to-back: push 8'h41, 8'h42, 8'h43 on consecutive cycles, GAP_CYCLES=4 -> three lcd_we pulses spaced exactly 6 cycles apart, in order A, B, C.
- Full and overflow: hold lcd_busy=1 and push 9 characters -> stall=1 after the 8th push; the 9th is dropped and overflow=1. Release lcd_busy -> characters 1 through 8 drain in order. Pulse clr_ovf -> overflow=0.
- Busy hold: lcd_busy=1 through GAP and for 10 further cycles -> FSM stays in WAIT with no lcd_we; the next pulse follows one edge after lcd_busy falls.
- Reset mid-stream: assert reset during ISSUE with level=3 -> lcd_we drops immediately; after release level=0 and no further pulses occur.
- With LCD_SCHED_CR_EXPAND_EN: push 8'h0A -> two pulses, 8'h0D then 8'h0A, spaced GAP_CYCLES+2 cycles apart; level goes 1 then 0 only after the second pulse.
